// File: rtl/gpu_cmd_sender.sv
// gpu_cmd_sender: buffers 32-bit host instructions and writes them MSB-first as four bytes on the GPU's 8-bit en/we/ack bus.
// Latency: a word offered to an empty, idle block raises o_en two cycles later. Each byte needs at least 2 cycles, and there is at least 1 idle cycle between instructions.
// Backpressure: o_cmd_ready drops while the FIFO is full. i_busy holds off the next instruction, but only at instruction boundaries.
//
// Ports:
//   i_clk, i_reset          clock; synchronous active-high reset
//   i_cmd, i_cmd_valid      host instruction word and its valid
//   o_cmd_ready             FIFO has room (combinational from the registered count)
//   o_en, o_we, o_data      bus enable, write strobe (same as o_en) and byte (registered)
//   i_ack, i_busy           GPU byte acknowledge (return-to-zero) and busy flag
//   o_idle                  FIFO empty and FSM idle (combinational from registered state)
//   o_error                 one-cycle pulse when an instruction is aborted on ack timeout
//   o_fifo_count            number of words queued

// gpu_cmd_fifo: generic synchronous FIFO. The head word is visible combinationally (first-word-fall-through).
// Latency: a pushed word becomes the head on the cycle after the push edge.
// Backpressure: the caller must not push when count == DEPTH. A push and a pop in the same cycle leave count unchanged.
module gpu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_dat,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign head_dat = mem[rd_ptr];

  // The storage array has no reset, because only the pointers and the count define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module gpu_cmd_sender #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic [31:0]                   i_cmd,
  input  logic                          i_cmd_valid,
  output logic                          o_cmd_ready,
  output logic                          o_en,
  output logic                          o_we,
  output logic [7:0]                    o_data,
  input  logic                          i_ack,
  input  logic                          i_busy,
  output logic                          o_idle,
  output logic                          o_error,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);
  localparam int              CW      = $clog2(FIFO_DEPTH) + 1;
  localparam int              TW      = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]   TMAX    = TW'(TIMEOUT);
  localparam logic [CW-1:0]   DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, DRIVE, RELEASE} state_t;

  state_t        state;
  logic [31:0]   shift;
  logic [2:0]    byte_idx;
  logic [TW-1:0] timer;
  logic [31:0]   head;
  logic          push;
  logic          pop;

  assign o_cmd_ready = (o_fifo_count < DEPTH_C);
  assign push        = i_cmd_valid && o_cmd_ready;
  assign o_idle      = (state == IDLE) && (o_fifo_count == '0);
  assign o_we        = o_en;

  // A new instruction starts only when i_ack is low.
  // After an abort, a GPU that is still holding ack cannot complete the first byte of the next word by mistake.
  assign pop = (state == IDLE) && (o_fifo_count != '0) && !i_busy && !i_ack;

  gpu_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk      (i_clk),
    .reset    (i_reset),
    .push     (push),
    .push_dat (i_cmd),
    .pop      (pop),
    .head_dat (head),
    .count    (o_fifo_count)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= IDLE;
      shift    <= '0;
      byte_idx <= '0;
      timer    <= '0;
      o_en     <= 1'b0;
      o_data   <= '0;
      o_error  <= 1'b0;
    end else begin
      o_error <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            shift    <= head;
            byte_idx <= '0;
            timer    <= '0;
            o_en     <= 1'b1;
            o_data   <= head[31:24];
            state    <= DRIVE;
          end
        end

        DRIVE: begin
          if (i_ack) begin
            shift    <= {shift[23:0], 8'h00};
            byte_idx <= byte_idx + 3'd1;
            timer    <= '0;
            o_en     <= 1'b0;
            state    <= RELEASE;
          end else if (timer == TMAX) begin
            // The GPU never acknowledged this byte, so drop the rest of the word.
            o_error  <= 1'b1;
            o_en     <= 1'b0;
            o_data   <= '0;
            timer    <= '0;
            byte_idx <= '0;
            state    <= IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        RELEASE: begin
          if (!i_ack) begin
            timer <= '0;
            if (byte_idx == 3'd4) begin
              o_data <= '0;
              state  <= IDLE;
            end else begin
              // shift has already moved the next byte to the top.
              o_en   <= 1'b1;
              o_data <= shift[31:24];
              state  <= DRIVE;
            end
          end else if (timer == TMAX) begin
            // The GPU is stuck with ack high, so abandon the word.
            o_error  <= 1'b1;
            o_en     <= 1'b0;
            o_data   <= '0;
            timer    <= '0;
            byte_idx <= '0;
            state    <= IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        default: begin
          o_en  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
